// File: rtl/mc_ctrl.sv
// Multicycle MIPS control sequencer: steps each instruction through FETCH..WB,
// drives datapath strobes/selects, counts retired instructions, traps on memory stall.
module mc_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic             clkin,
    input  logic             reset,
    input  logic [5:0]       opCode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic [1:0]       pcSource,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             regDst,
    output logic             memToReg,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [3:0]       state,
    output logic             retire,
    output logic [CNT_W-1:0] instCount,
    output logic             trap
);

    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_RWB     = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_JUMP    = 4'd9;
    localparam logic [3:0] S_ADDI_EX = 4'd10;
    localparam logic [3:0] S_ADDI_WB = 4'd11;
    localparam logic [3:0] S_TRAP    = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // A zero TIMEOUT still needs a 1-bit counter to keep the declaration legal.
    localparam int            WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WAIT_W-1:0] TO_V = WAIT_W'(TIMEOUT);
    localparam logic          TO_EN = (TIMEOUT != 0);

    logic [3:0]        r_state;
    logic [CNT_W-1:0]  r_count;
    logic [WAIT_W-1:0] r_wait;
    logic [3:0]        w_next;
    logic              w_timeout;
    logic              w_stay_wait;

    assign w_timeout = TO_EN && (r_wait == TO_V) && !memReady;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:   if (memReady) w_next = S_DECODE;
                       else if (w_timeout) w_next = S_TRAP;
            S_DECODE: begin
                case (opCode)
                    OP_RTYPE:      w_next = S_EXEC;
                    OP_LW, OP_SW:  w_next = S_MEMADR;
                    OP_BEQ:        w_next = S_BRANCH;
                    OP_J:          w_next = S_JUMP;
                    OP_ADDI:       w_next = S_ADDI_EX;
                    default:       w_next = S_TRAP;
                endcase
            end
            S_MEMADR:  w_next = (opCode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (memReady) w_next = S_MEMWB;
                       else if (w_timeout) w_next = S_TRAP;
            S_MEMWB:   w_next = S_FETCH;
            S_MEMWR:   if (memReady) w_next = S_FETCH;
                       else if (w_timeout) w_next = S_TRAP;
            S_EXEC:    w_next = S_RWB;
            S_RWB:     w_next = S_FETCH;
            S_BRANCH:  w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_ADDI_EX: w_next = S_ADDI_WB;
            S_ADDI_WB: w_next = S_FETCH;
            S_TRAP:    w_next = S_TRAP;
            default:   w_next = S_TRAP;
        endcase
    end

    // Counter only runs while stalled in a memory state; entry, ready and exit all clear it.
    assign w_stay_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                         && (w_next == r_state) && !memReady;

    always_ff @(posedge clkin) begin
        if (!reset) begin
            r_state <= S_FETCH;
            r_count <= '0;
            r_wait  <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_stay_wait ? (r_wait + WAIT_W'(1)) : '0;
            if (retire) r_count <= r_count + CNT_W'(1);
        end
    end

    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        pcSource    = 2'b00;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        retire      = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    memRead = 1'b1;
                    aluSrcB = 2'b01;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                S_DECODE:  aluSrcB = 2'b11;
                S_MEMADR: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_MEMRD: begin
                    memRead = 1'b1;
                    iorD    = 1'b1;
                end
                S_MEMWB: begin
                    regWrite = 1'b1;
                    memToReg = 1'b1;
                    retire   = 1'b1;
                end
                S_MEMWR: begin
                    memWrite = 1'b1;
                    iorD     = 1'b1;
                    retire   = memReady;
                end
                S_EXEC: begin
                    aluSrcA = 1'b1;
                    aluOp   = 2'b10;
                end
                S_RWB: begin
                    regWrite = 1'b1;
                    regDst   = 1'b1;
                    retire   = 1'b1;
                end
                S_BRANCH: begin
                    aluSrcA     = 1'b1;
                    aluOp       = 2'b01;
                    pcWriteCond = 1'b1;
                    pcSource    = 2'b01;
                    retire      = 1'b1;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSource = 2'b10;
                    retire   = 1'b1;
                end
                S_ADDI_EX: begin
                    aluSrcA = 1'b1;
                    aluSrcB = 2'b10;
                end
                S_ADDI_WB: begin
                    regWrite = 1'b1;
                    retire   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state     = r_state;
    assign instCount = r_count;
    assign trap      = (r_state == S_TRAP);

endmodule
